// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// NOP word and default bus widths.
package fetch_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] NOP = 32'h0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_STALL = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: instruction, its word address and a valid flag.
// A bubble overrides any load and leaves a NOP marked invalid.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              hold,
    input  logic              bubble,
    input  logic [DATA_W-1:0] next_instr,
    input  logic [ADDR_W-1:0] next_pc,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic              valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= DATA_W'(NOP);
            pc    <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= DATA_W'(NOP);
            valid <= 1'b0;
        end else if (load && !hold) begin
            instr <= next_instr;
            pc    <= next_pc;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, strobes the instruction memory,
// and arbitrates halt/jump/branch/stall into one fetch decision per cycle.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_req,
    output logic              imem_read,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus1,
    output logic              ifid_valid,
    output logic [7:0]        fetch_count,
    output logic [2:0]        state
);

    localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);

    fetch_state_t      cur_state;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        bubble_cnt;
    logic [7:0]        count;

    logic              running;
    logic              issuing;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              do_halt;
    logic              do_redirect;
    logic              do_stall;
    logic              do_fetch;
    logic              ifid_bubble;

    always_comb begin
        running     = (cur_state == S_FETCH) || (cur_state == S_STALL) || (cur_state == S_FLUSH);
        issuing     = (cur_state == S_FETCH) || (cur_state == S_STALL);
        redirect    = jump_taken || branch_taken;
        target      = jump_taken ? jump_target : branch_target;
        do_halt     = running && halt_req;
        do_redirect = running && !halt_req && redirect;
        do_stall    = issuing && !halt_req && !redirect && stall;
        do_fetch    = issuing && !halt_req && !redirect && !stall;
        ifid_bubble = do_halt || do_redirect || (cur_state == S_FLUSH) || (cur_state == S_HALT);
    end

    // Priority: halt > jump > branch > stall > normal; FLUSH ignores stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state  <= S_IDLE;
            pc         <= '0;
            bubble_cnt <= 3'd0;
            count      <= 8'd0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (en) cur_state <= S_FETCH;
                end
                S_FETCH, S_STALL, S_FLUSH: begin
                    if (do_halt) begin
                        cur_state <= S_HALT;
                    end else if (do_redirect) begin
                        pc         <= target;
                        bubble_cnt <= FLUSH_LOAD;
                        cur_state  <= (FLUSH_CYCLES == 0) ? S_FETCH : S_FLUSH;
                    end else if (cur_state == S_FLUSH) begin
                        if (bubble_cnt == 3'd0) cur_state <= S_FETCH;
                        else                    bubble_cnt <= bubble_cnt - 3'd1;
                    end else if (stall) begin
                        cur_state <= S_STALL;
                    end else begin
                        pc        <= pc + ADDR_W'(1);
                        cur_state <= S_FETCH;
                        if (count != 8'd255) count <= count + 8'd1;
                    end
                end
                S_HALT: cur_state <= S_HALT;
                default: cur_state <= S_IDLE;
            endcase
        end
    end

    ifid_reg #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ifid (
        .clk       (clk),
        .reset     (reset),
        .load      (do_fetch),
        .hold      (do_stall),
        .bubble    (ifid_bubble),
        .next_instr(imem_rdata),
        .next_pc   (pc),
        .instr     (ifid_instr),
        .pc        (ifid_pc),
        .valid     (ifid_valid)
    );

    assign imem_read     = issuing;
    assign imem_addr     = pc;
    assign ifid_pc_plus1 = ifid_pc + ADDR_W'(1);
    assign fetch_count   = count;
    assign state         = cur_state;

endmodule
